toggle_to_pulse_rx: RTL

Receive-side end of the toggle-based clock-domain crossing. A toggle level driven from another clock domain is synchronized into the local clock, and each level change is converted into a one-cycle event pulse. The source holds a bundled data word stable across each toggle; this block captures that word into a small FIFO and presents it on a valid/ready interface. It sits in the consumer clock domain, for example the FIFO/host side of the UART RX path.

---
 rtl/toggle_to_pulse_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/toggle_to_pulse_rx.sv
// toggle_to_pulse_rx
// Receive end of a toggle-based clock-domain crossing. The incoming toggle
// level is synchronized, each level change becomes a one-cycle pulse, and
// the bundled data word is captured into a small show-ahead FIFO that is
// drained through a valid/ready interface.
module toggle_to_pulse_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              toggle_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              pulse_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              overflow,
   output logic [CNT_W-1:0]  event_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Two-state controller: INIT absorbs whatever level the toggle already
   // has when reset is released, RUN turns level changes into events.
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // INIT lasts SYNC_STAGES+1 cycles: long enough for the synchronizer to
   // fill and for r_prev to copy the settled level.
   localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

   // Synchronizer and edge detection
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [0:0]             r_state;
   logic [2:0]             r_init_cnt;

   // Event outputs
   logic                   r_pulse;
   logic [CNT_W-1:0]       r_event_count;
   logic                   r_overflow;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [DATA_W-1:0]      r_mem [DEPTH];
   logic [AW:0]            r_wr_ptr;
   logic [AW:0]            r_rd_ptr;
   logic                   r_out_valid;
   logic [DATA_W-1:0]      r_out_data;

   logic                   w_sync_q;
   logic                   w_edge;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_push;
   logic [AW:0]            w_wr_ptr_next;
   logic [AW:0]            w_rd_ptr_next;
   logic                   w_valid_next;
   logic [DATA_W-1:0]      w_head_next;

   // Edge detect, FIFO handshake and next-head selection
   always_comb begin
      w_sync_q      = r_sync[SYNC_STAGES-1];
      w_edge        = (r_state == ST_RUN) && (w_sync_q != r_prev);
      w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop         = r_out_valid && out_ready;
      // A full FIFO still accepts an event when the head leaves this cycle.
      w_push        = w_edge && (!w_full || w_pop);
      w_wr_ptr_next = w_push ? (r_wr_ptr + (AW+1)'(1)) : r_wr_ptr;
      w_rd_ptr_next = w_pop  ? (r_rd_ptr + (AW+1)'(1)) : r_rd_ptr;
      w_valid_next  = (w_wr_ptr_next != w_rd_ptr_next);
      // If the new head is the slot being written right now, bypass the
      // memory so out_data shows the incoming word on the same edge.
      if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
         w_head_next = data_in;
      end else begin
         w_head_next = r_mem[w_rd_ptr_next[AW-1:0]];
      end
   end

   // Shift the asynchronous toggle through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], toggle_in};
      end
   end

   // Controller: track the synchronized level and leave INIT after settling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_init_cnt <= 3'd0;
         r_prev     <= 1'b0;
      end else begin
         r_prev <= w_sync_q;
         if (r_state == ST_INIT) begin
            if (r_init_cnt == INIT_LAST) begin
               r_state <= ST_RUN;
            end else begin
               r_init_cnt <= r_init_cnt + 3'd1;
            end
         end
      end
   end

   // Event pulse, wrapping event counter and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pulse       <= 1'b0;
         r_event_count <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_pulse <= w_edge;
         if (w_edge) begin
            r_event_count <= r_event_count + CNT_W'(1);
         end
         if (w_edge && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // FIFO pointers and registered show-ahead head word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_next;
         r_rd_ptr    <= w_rd_ptr_next;
         r_out_valid <= w_valid_next;
         if (w_valid_next) begin
            r_out_data <= w_head_next;
         end
      end
   end

   // FIFO storage write; contents need no reset since pointers gate them
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= data_in;
      end
   end

   assign pulse_out   = r_pulse;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign overflow    = r_overflow;
   assign event_count = r_event_count;

endmodule
